lfsr_load_ctrl: RTL and testbench



---
 rtl/lfsr_load_ctrl_if.sv | 33 +++
 rtl/lfsr_load_ctrl.sv | 110 +++++++++++
 tb/tb_lfsr_load_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_load_ctrl_if.sv
// ============================================================================
// Module   : lfsr_load_ctrl_if
// Brief    : Command/status bundle between a command source and lfsr_load_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lfsr_load_ctrl_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] steps;
    logic             en;
    logic             L;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_left;

    modport master (
        output start, seed, steps, en,
        input  L, q, busy, done, steps_left
    );

    modport slave (
        input  start, seed, steps, en,
        output L, q, busy, done, steps_left
    );
endinterface

`default_nettype wire

// File: rtl/lfsr_load_ctrl.sv
// ============================================================================
// Module   : lfsr_load_ctrl
// Brief    : Load/shift sequencer for a mux-flop LFSR chain; owns select L.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_load_ctrl #(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = 3'b100,
    parameter int               CNT_W = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    lfsr_load_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] seed_q;
    logic [CNT_W-1:0] steps_left_q;
    logic             l_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] shift_d;

    // One LFSR step: MSB wraps to stage 0 and is XORed into tapped stages.
    always_comb begin
        shift_d    = '0;
        shift_d[0] = q_q[WIDTH-1];
        for (int i = 1; i < WIDTH; i++) begin
            shift_d[i] = q_q[i-1] ^ (TAPS[i] & q_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            q_q          <= '0;
            seed_q       <= '0;
            steps_left_q <= '0;
            l_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        seed_q       <= bus.seed;
                        steps_left_q <= bus.steps;
                        state_q      <= S_LOAD;
                        l_q          <= 1'b1;
                        busy_q       <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        l_q     <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    q_q <= seed_q;
                    l_q <= 1'b0;
                    if (steps_left_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    // The nonzero guard keeps the counter from ever wrapping.
                    if (bus.en && steps_left_q != '0) begin
                        q_q          <= shift_d;
                        steps_left_q <= steps_left_q - CNT_W'(1);
                        if (steps_left_q == CNT_W'(1)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    l_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.L          = l_q;
    assign bus.q          = q_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.steps_left = steps_left_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_load_ctrl.sv
// ============================================================================
// Module   : tb_lfsr_load_ctrl
// Brief    : Self-checking bench for lfsr_load_ctrl against a command-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_load_ctrl;

    localparam int           W  = 3;
    localparam int           CW = 8;
    localparam logic [W-1:0] TP = 3'b100;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    lfsr_load_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    lfsr_load_ctrl #(.WIDTH(W), .TAPS(TP), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W+CW+2:0] dut_vec;
    assign dut_vec = {bus.L, bus.busy, bus.done, bus.q, bus.steps_left};

    // Command-level model: edges since the accepted start and shifts performed.
    bit           m_on     = 1'b0;
    bit           m_fin    = 1'b0;
    bit           m_fin_now = 1'b0;
    int           m_e      = 0;
    int           m_n      = 0;
    int           m_steps  = 0;
    logic [W-1:0] m_seed   = '0;
    logic [W-1:0] m_qhold  = '0;

    function automatic logic [W-1:0] lfsr_pow(input logic [W-1:0] s, input int n);
        int v = int'(s);
        int msb;
        for (int k = 0; k < n; k++) begin
            msb = (v >> (W - 1)) & 1;
            v   = ((v << 1) | msb) & ((1 << W) - 1);
            if (msb == 1) v = v ^ (int'(TP) & ~1);
        end
        return W'(v);
    endfunction

    function automatic logic exp_busy();
        return m_on && !m_fin;
    endfunction

    function automatic logic [W-1:0] exp_q();
        return (m_on && m_e >= 1) ? lfsr_pow(m_seed, m_n) : m_qhold;
    endfunction

    function automatic logic [W+CW+2:0] exp_vec();
        logic [CW-1:0] left;
        left = m_on ? CW'(m_steps - m_n) : '0;
        return {(m_on && m_e == 0), exp_busy(), (m_on && m_fin_now), exp_q(), left};
    endfunction

    task automatic tick(input logic r, input logic st, input logic [W-1:0] sd,
                        input logic [CW-1:0] sp, input logic e);
        logic         pre_busy;
        logic [W-1:0] pre_q;
        reset     = r;
        bus.start = st;
        bus.seed  = sd;
        bus.steps = sp;
        bus.en    = e;
        pre_busy  = exp_busy();
        pre_q     = exp_q();
        @(posedge clk);
        m_fin_now = 1'b0;
        if (r) begin
            m_on    = 1'b0;
            m_qhold = '0;
        end else if (st && !pre_busy) begin
            m_qhold = pre_q;
            m_on    = 1'b1;
            m_e     = 0;
            m_n     = 0;
            m_seed  = sd;
            m_steps = int'(sp);
            m_fin   = 1'b0;
        end else if (m_on && !m_fin) begin
            m_e++;
            if (m_e == 1) begin
                if (m_steps == 0) begin m_fin = 1'b1; m_fin_now = 1'b1; end
            end else if (e) begin
                m_n++;
                if (m_n == m_steps) begin m_fin = 1'b1; m_fin_now = 1'b1; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 3'b111, 8'd5, 1);
        tick(1, 0, 3'b000, 8'd0, 0);
        checks++;
        if (dut_vec !== '0) begin
            fails++;
            $display("FAIL reset_state got=%h exp=0", dut_vec);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_basic();
        int pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick(0, i == 0, 3'b001, 8'd3, 1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL basic_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (bus.done === 1'b1) pulses++;
            if (i == 0) begin
                checks++;
                if (bus.L !== 1'b1) begin fails++; $display("FAIL basic_L got=%b exp=1", bus.L); end
            end
            if (i == 4) begin
                checks++;
                if ({bus.done, bus.busy, bus.q} !== {2'b10, 3'b101}) begin
                    fails++;
                    $display("FAIL basic_done got=%b%b q=%b exp=10 q=101", bus.done, bus.busy, bus.q);
                end
            end
        end
        checks++;
        if (pulses != 1) begin fails++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_period();
        for (int i = 0; i < 10; i++) begin
            tick(0, i == 0, 3'b001, 8'd7, 1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL period_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (i == 8) begin
                checks++;
                if (bus.done !== 1'b1 || bus.q !== 3'b001) begin
                    fails++;
                    $display("FAIL period_done got=%b q=%b exp=1 q=001", bus.done, bus.q);
                end
            end
        end
    endtask

    task automatic test_zero_steps();
        for (int i = 0; i < 4; i++) begin
            tick(0, i == 0, 3'b110, 8'd0, 1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL zero_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (i == 1) begin
                checks++;
                if (bus.done !== 1'b1 || bus.q !== 3'b110 || bus.busy !== 1'b0) begin
                    fails++;
                    $display("FAIL zero_done got=%b q=%b busy=%b exp=1 q=110 busy=0",
                             bus.done, bus.q, bus.busy);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 9; i++) begin
            tick(0, i == 0, 3'b001, 8'd3, !(i == 3 || i == 4));
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL stall_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (bus.q !== 3'b010 || bus.steps_left !== 8'd2) begin
                    fails++;
                    $display("FAIL stall_freeze cyc=%0d got q=%b left=%0d exp q=010 left=2",
                             i, bus.q, bus.steps_left);
                end
            end
            if (i == 6) begin
                checks++;
                if (bus.done !== 1'b1 || bus.q !== 3'b101) begin
                    fails++;
                    $display("FAIL stall_done got=%b q=%b exp=1 q=101", bus.done, bus.q);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  sd;
        logic [CW-1:0] sp;
        for (int i = 0; i < 10; i++) begin
            sd = (i == 2) ? 3'b111 : (i == 5) ? 3'b011 : 3'b001;
            sp = (i == 2) ? 8'd5 : (i == 5) ? 8'd1 : 8'd3;
            tick(0, (i == 0) || (i == 2) || (i == 5), sd, sp, 1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL b2b_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (i == 4 || i == 7) begin
                checks++;
                if (bus.done !== 1'b1 || bus.q !== ((i == 4) ? 3'b101 : 3'b110)) begin
                    fails++;
                    $display("FAIL b2b_done cyc=%0d got=%b q=%b exp=1 q=%b", i, bus.done, bus.q,
                             (i == 4) ? 3'b101 : 3'b110);
                end
            end
            if (i == 5) begin
                checks++;
                if (bus.L !== 1'b1 || bus.busy !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_reload got L=%b busy=%b exp L=1 busy=1", bus.L, bus.busy);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0;
        for (int i = 0; i < 11; i++) begin
            tick(i == 4, i == 0, 3'b001, 8'd5, 1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL rstrun_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (i == 3) begin
                checks++;
                if (bus.q !== 3'b100) begin fails++; $display("FAIL rstrun_pre got q=%b exp=100", bus.q); end
            end
            if (i == 4) begin
                checks++;
                if (dut_vec !== '0) begin fails++; $display("FAIL rstrun_clear got=%h exp=0", dut_vec); end
            end
            if (i > 4 && bus.done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin fails++; $display("FAIL rstrun_nodone got=%0d exp=0", pulses); end
    endtask

    task automatic test_random();
        logic r, st, e;
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom % 150) == 0;
            st = ($urandom % 3) == 0;
            e  = ($urandom % 4) != 0;
            tick(r, st, W'($urandom), CW'($urandom_range(0, 9)), e);
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.seed  = '0;
        bus.steps = '0;
        bus.en    = 1'b0;
        test_reset();
        test_basic();
        test_period();
        test_zero_steps();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
